// File: rtl/product_bcd_converter_pkg.sv
// product_bcd_converter_pkg: shared FSM encodings and default sizes for the product BCD converter
package product_bcd_converter_pkg;
  localparam int WIDTH_DEF  = 12;
  localparam int DIGITS_DEF = 4;
  localparam int DIGIT_W    = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/product_bcd_converter_bcd_add3.sv
// bcd_add3: combinational digit corrector for shift-add-3 (d_o = d_i >= 5 ? d_i + 3 : d_i)
module bcd_add3
  import product_bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);
  assign d_o = (d_i >= DIGIT_W'(5)) ? d_i + DIGIT_W'(3) : d_i;
endmodule

// File: rtl/product_bcd_converter.sv
// product_bcd_converter: iterative two's-complement product to sign + packed BCD converter
// Ports: clk, rst (async, active-low), start/prod_in request, busy/done handshake,
// sign and bcd (thousands in the top nibble) hold the last completed result.
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          prod_in,
  output logic                      busy,
  output logic                      done,
  output logic                      sign,
  output logic [DIGIT_W*DIGITS-1:0] bcd
);
  localparam int BW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    prod_q, prod_d, mag_q, mag_d;
  logic [BW-1:0]       scr_q, scr_d, bcd_q, bcd_d, scr_fix;
  logic                neg_q, neg_d, sign_q, sign_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH:0]      abs_w;
  logic [BW+WIDTH-1:0] sh;
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.d_i(scr_q[g*DIGIT_W +: DIGIT_W]), .d_o(scr_fix[g*DIGIT_W +: DIGIT_W]));
  end
  // Extra bit keeps -2^(WIDTH-1) exact; its top bit is always 0 and is pre-shifted into scratch.
  assign abs_w = prod_q[WIDTH-1] ? {1'b0, ~prod_q} + (WIDTH+1)'(1) : {1'b0, prod_q};
  assign sh    = {scr_fix, mag_q} << 1;
  assign busy  = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign done  = state_q == ST_DONE;
  assign sign  = sign_q;
  assign bcd   = bcd_q;
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = start ? ST_LOAD : ST_IDLE;
        prod_d  = start ? prod_in : prod_q;
      end
      ST_LOAD: begin
        neg_d   = prod_q[WIDTH-1];
        mag_d   = abs_w[WIDTH-1:0];
        scr_d   = {{(BW-1){1'b0}}, abs_w[WIDTH]};
        cnt_d   = CW'(WIDTH);
        state_d = ST_SHIFT;
      end
      default: begin
        scr_d   = sh[BW+WIDTH-1:WIDTH];
        mag_d   = sh[WIDTH-1:0];
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_SHIFT;
        bcd_d   = (cnt_q == CW'(1)) ? sh[BW+WIDTH-1:WIDTH] : bcd_q;
        sign_d  = (cnt_q == CW'(1)) ? neg_q : sign_q;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      prod_q  <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
    end
  end
endmodule

// File: tb/tb_product_bcd_converter.sv
// tb_product_bcd_converter: directed + random checks of the product BCD converter against an arithmetic model
module tb_product_bcd_converter;
  logic        clk = 1'b0;
  logic        rst, start, busy, done, sign;
  logic [11:0] prod_in;
  logic [15:0] bcd;
  int          checks = 0;
  int          errors = 0;
  product_bcd_converter dut (
    .clk(clk), .rst(rst), .start(start), .prod_in(prod_in),
    .busy(busy), .done(done), .sign(sign), .bcd(bcd)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [16:0] ref_conv(input logic [11:0] v);
    int m;
    m = v[11] ? 4096 - int'(v) : int'(v);
    return {v[11], 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction
  task automatic conv(input logic [11:0] v, input bit keep_start);
    logic [16:0] e;
    logic [15:0] hold;
    int n, busy_n;
    bit stable;
    e = ref_conv(v);
    hold = bcd;
    stable = 1;
    n = 0;
    busy_n = 0;
    prod_in = v;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (i == 0 && !keep_start) begin
        start = 1'b0;
        prod_in = 12'($urandom);
      end
      n++;
      if (busy) begin
        busy_n++;
        if (bcd !== hold) stable = 0;
      end
      if (done) break;
    end
    chk($sformatf("latency %h", v), n, 14);
    chk($sformatf("busy_len %h", v), busy_n, 13);
    chk($sformatf("stable %h", v), 32'(stable), 1);
    chk($sformatf("bcd %h", v), bcd, e[15:0]);
    chk($sformatf("sign %h", v), sign, e[16]);
  endtask
  initial begin
    int n, extra;
    rst = 1'b0;
    start = 1'b0;
    prod_in = '0;
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sign", sign, 0);
    chk("rst_bcd", bcd, 0);
    rst = 1'b1;
    tick;
    conv(12'h3E0, 0);
    chk("bcd_992", bcd, 16'h0992);
    conv(12'hC20, 0);
    chk("neg_992", {sign, bcd}, 17'h10992);
    conv(12'h400, 0);
    chk("bcd_1024", {sign, bcd}, 17'h01024);
    conv(12'h800, 0);
    chk("bcd_m2048", {sign, bcd}, 17'h12048);
    conv(12'h000, 0);
    chk("bcd_zero", {sign, bcd}, 17'h00000);
    conv(12'hFFF, 0);
    chk("bcd_m1", {sign, bcd}, 17'h10001);
    prod_in = 12'h007;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 1;
    repeat (3) begin tick; n++; end
    prod_in = 12'h3E0;
    start = 1'b1;
    tick;
    n++;
    start = 1'b0;
    prod_in = '0;
    for (int i = 0; i < 30 && !done; i++) begin tick; n++; end
    chk("ign_latency", n, 14);
    chk("ign_bcd", {sign, bcd}, 17'h00007);
    extra = 0;
    repeat (20) begin tick; if (done) extra++; end
    chk("ign_no_extra_done", extra, 0);
    prod_in = 12'h3E0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sign", sign, 0);
    chk("arst_bcd", bcd, 0);
    repeat (2) tick;
    rst = 1'b1;
    tick;
    conv(12'h019, 0);
    chk("post_rst_25", bcd, 16'h0025);
    conv(12'h00C, 1);
    chk("b2b_first", {sign, bcd}, 17'h00012);
    conv(12'hFF4, 0);
    chk("b2b_second", {sign, bcd}, 17'h10012);
    repeat (16) conv(12'($urandom), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
